// File: rtl/bounce_pkg.sv
// Shared widths, update-FSM encoding and per-ball reset values for the
// bounce sprite engine.
package bounce_pkg;

    localparam int POS_W   = 10;
    localparam int VEL_W   = 4;
    localparam int SUM_W   = 21;
    localparam int RGB_W   = 6;
    localparam int FRAME_W = 10;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } upd_state_t;

    // Balls start in a row, spaced one diameter plus an 8-pixel gap apart.
    function automatic logic [POS_W-1:0] reset_pos_x(input int idx, input int radius);
        return POS_W'(radius + 32'sd1 + idx * (32'sd2 * radius + 32'sd8));
    endfunction

    function automatic logic [POS_W-1:0] reset_pos_y(input int v_active);
        return POS_W'(v_active / 32'sd2);
    endfunction

    function automatic logic [VEL_W-1:0] reset_vel_x(input int idx);
        int mag;
        mag = 32'sd1 + (idx % 32'sd3);
        return ((idx % 32'sd2) == 32'sd1) ? VEL_W'(-mag) : VEL_W'(mag);
    endfunction

    function automatic logic [VEL_W-1:0] reset_vel_y(input int idx);
        int mag;
        mag = 32'sd1 + ((idx + 32'sd1) % 32'sd3);
        return ((idx % 32'sd4) >= 32'sd2) ? VEL_W'(-mag) : VEL_W'(mag);
    endfunction

endpackage

// File: rtl/bounce_sprite_engine_if.sv
// Video-side bundle of the sprite engine: timing/control in, pixel stream,
// delayed syncs and status out.
interface bounce_sprite_engine_if;
    import bounce_pkg::*;

    logic [POS_W-1:0]   hpos;
    logic [POS_W-1:0]   vpos;
    logic               display_on;
    logic               hsync_in;
    logic               vsync_in;
    logic               pause;
    logic [RGB_W-1:0]   rgb;
    logic               hsync_out;
    logic               vsync_out;
    logic               busy;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        output hpos, vpos, display_on, hsync_in, vsync_in, pause,
        input  rgb, hsync_out, vsync_out, busy, frame_count
    );

    modport slave (
        input  hpos, vpos, display_on, hsync_in, vsync_in, pause,
        output rgb, hsync_out, vsync_out, busy, frame_count
    );

endinterface

// File: rtl/bounce_axis_step.sv
// One-axis move with wall bounce: advances a position by its velocity and
// clamps/reflects against [RADIUS, LIMIT-1-RADIUS].
module bounce_axis_step
    import bounce_pkg::*;
#(
    parameter int LIMIT  = 640,
    parameter int RADIUS = 16
) (
    input  logic [POS_W-1:0] i_pos,
    input  logic [VEL_W-1:0] i_vel,
    output logic [POS_W-1:0] o_pos,
    output logic [VEL_W-1:0] o_vel
);

    localparam logic signed [11:0] LO_BOUND = 12'(RADIUS);
    localparam logic signed [11:0] HI_BOUND = 12'(LIMIT - 1 - RADIUS);
    localparam logic [POS_W-1:0]   LO_POS   = POS_W'(RADIUS);
    localparam logic [POS_W-1:0]   HI_POS   = POS_W'(LIMIT - 1 - RADIUS);

    logic signed [11:0] w_next;
    logic               w_moving_neg;
    logic               w_moving_pos;
    logic [VEL_W-1:0]   w_vel_flip;

    assign w_next       = $signed({2'b00, i_pos})
                        + $signed({{(12-VEL_W){i_vel[VEL_W-1]}}, i_vel});
    assign w_moving_neg = i_vel[VEL_W-1];
    assign w_moving_pos = ~i_vel[VEL_W-1] & (i_vel != {VEL_W{1'b0}});
    assign w_vel_flip   = {VEL_W{1'b0}} - i_vel;

    // Bounce: clamp to the wall and reverse direction on overshoot.
    always_comb begin
        o_pos = w_next[POS_W-1:0];
        o_vel = i_vel;
        if (w_moving_neg && (w_next < LO_BOUND)) begin
            o_pos = LO_POS;
            o_vel = w_vel_flip;
        end else if (w_moving_pos && (w_next > HI_BOUND)) begin
            o_pos = HI_POS;
            o_vel = w_vel_flip;
        end else begin
            o_pos = w_next[POS_W-1:0];
            o_vel = i_vel;
        end
    end

endmodule

// File: rtl/bounce_sprite_engine.sv
// Multi-ball renderer: moves NUM_BALLS sprites once per frame during vertical
// blanking and composites them over a stripe background into a registered RGB stream.
module bounce_sprite_engine
    import bounce_pkg::*;
#(
    parameter int NUM_BALLS       = 4,
    parameter int RADIUS          = 16,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1,
    // ball 0 yellow, ball 1 white, balls 2 and 3 magenta
    parameter logic [RGB_W*NUM_BALLS-1:0] BALL_COLORS = 24'hCF_3F_FC
) (
    input  logic                   clk,
    input  logic                   reset,
    bounce_sprite_engine_if.slave  bus
);

    localparam int               IDX_W     = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BALLS - 1);
    localparam logic [SUM_W-1:0] R_SQ      = SUM_W'(RADIUS * RADIUS);
    localparam logic             SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    upd_state_t                     r_state;
    upd_state_t                     w_state_nxt;
    logic [IDX_W-1:0]               r_idx;
    logic [IDX_W-1:0]               w_idx_nxt;
    logic [FRAME_W-1:0]             r_frame_count;
    logic [FRAME_W-1:0]             w_fc_nxt;

    logic                           r_vs_act_d;
    logic                           w_vs_act;
    logic                           w_tick;

    logic [NUM_BALLS-1:0][POS_W-1:0] r_pos_x;
    logic [NUM_BALLS-1:0][POS_W-1:0] r_pos_y;
    logic [NUM_BALLS-1:0][VEL_W-1:0] r_vel_x;
    logic [NUM_BALLS-1:0][VEL_W-1:0] r_vel_y;

    logic [POS_W-1:0]               w_cur_pos_x;
    logic [POS_W-1:0]               w_cur_pos_y;
    logic [VEL_W-1:0]               w_cur_vel_x;
    logic [VEL_W-1:0]               w_cur_vel_y;
    logic [POS_W-1:0]               w_step_pos_x;
    logic [POS_W-1:0]               w_step_pos_y;
    logic [VEL_W-1:0]               w_step_vel_x;
    logic [VEL_W-1:0]               w_step_vel_y;

    logic [NUM_BALLS:0][RGB_W-1:0]  w_chain;
    logic [4:0]                     w_vsum_lo;
    logic [RGB_W-1:0]               w_bg;

    logic [RGB_W-1:0]               r_rgb;
    logic                           r_hsync_out;
    logic                           r_vsync_out;

    assign w_vs_act = (SYNC_ACTIVE_LOW != 0) ? ~bus.vsync_in : bus.vsync_in;
    assign w_tick   = w_vs_act & ~r_vs_act_d;

    // Previous vsync level; resets "active" so a vsync already asserted at reset release is not a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_act_d <= 1'b1;
        end else begin
            r_vs_act_d <= w_vs_act;
        end
    end

    // Update FSM state, ball index and frame counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= {IDX_W{1'b0}};
            r_frame_count <= {FRAME_W{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_frame_count <= w_fc_nxt;
        end
    end

    // Next-state: a non-paused tick starts a sweep over all balls, one per clock.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_fc_nxt    = r_frame_count;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && !bus.pause) begin
                    w_state_nxt = ST_UPDATE;
                    w_idx_nxt   = {IDX_W{1'b0}};
                    w_fc_nxt    = r_frame_count + 10'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = {IDX_W{1'b0}};
                end else begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = {IDX_W{1'b0}};
            end
        endcase
    end

    assign w_cur_pos_x = r_pos_x[r_idx];
    assign w_cur_pos_y = r_pos_y[r_idx];
    assign w_cur_vel_x = r_vel_x[r_idx];
    assign w_cur_vel_y = r_vel_y[r_idx];

    bounce_axis_step #(
        .LIMIT  (H_ACTIVE),
        .RADIUS (RADIUS)
    ) u_step_x (
        .i_pos (w_cur_pos_x),
        .i_vel (w_cur_vel_x),
        .o_pos (w_step_pos_x),
        .o_vel (w_step_vel_x)
    );

    bounce_axis_step #(
        .LIMIT  (V_ACTIVE),
        .RADIUS (RADIUS)
    ) u_step_y (
        .i_pos (w_cur_pos_y),
        .i_vel (w_cur_vel_y),
        .o_pos (w_step_pos_y),
        .o_vel (w_step_vel_y)
    );

    // Ball state: only the ball selected by r_idx is written during a sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_pos_x[i] <= reset_pos_x(i, RADIUS);
                r_pos_y[i] <= reset_pos_y(V_ACTIVE);
                r_vel_x[i] <= reset_vel_x(i);
                r_vel_y[i] <= reset_vel_y(i);
            end
        end else if (r_state == ST_UPDATE) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_pos_x[i] <= w_step_pos_x;
                    r_pos_y[i] <= w_step_pos_y;
                    r_vel_x[i] <= w_step_vel_x;
                    r_vel_y[i] <= w_step_vel_y;
                end
            end
        end
    end

    // Bit 4 of (vpos + frame_count) only depends on the low five bits of each operand.
    assign w_vsum_lo           = bus.vpos[4:0] + r_frame_count[4:0];
    assign w_bg                = {4'b0000, bus.hpos[7], w_vsum_lo[4]};
    assign w_chain[NUM_BALLS]  = w_bg;

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
        logic [POS_W-1:0] w_dx;
        logic [POS_W-1:0] w_dy;
        logic [SUM_W-1:0] w_dx_ext;
        logic [SUM_W-1:0] w_dy_ext;
        logic [SUM_W-1:0] w_dist_sq;

        assign w_dx      = (bus.hpos >= r_pos_x[g]) ? (bus.hpos - r_pos_x[g]) : (r_pos_x[g] - bus.hpos);
        assign w_dy      = (bus.vpos >= r_pos_y[g]) ? (bus.vpos - r_pos_y[g]) : (r_pos_y[g] - bus.vpos);
        assign w_dx_ext  = {{(SUM_W-POS_W){1'b0}}, w_dx};
        assign w_dy_ext  = {{(SUM_W-POS_W){1'b0}}, w_dy};
        assign w_dist_sq = (w_dx_ext * w_dx_ext) + (w_dy_ext * w_dy_ext);
        // Chained from the top index down, so the lowest-index hit ends up in w_chain[0].
        assign w_chain[g] = (w_dist_sq < R_SQ) ? BALL_COLORS[RGB_W*g +: RGB_W] : w_chain[g+1];
    end

    // Output stage: pixel colour and syncs share one register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb       <= {RGB_W{1'b0}};
            r_hsync_out <= SYNC_IDLE;
            r_vsync_out <= SYNC_IDLE;
        end else begin
            r_rgb       <= bus.display_on ? w_chain[0] : {RGB_W{1'b0}};
            r_hsync_out <= bus.hsync_in;
            r_vsync_out <= bus.vsync_in;
        end
    end

    assign bus.rgb         = r_rgb;
    assign bus.hsync_out   = r_hsync_out;
    assign bus.vsync_out   = r_vsync_out;
    assign bus.busy        = (r_state == ST_UPDATE);
    assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Self-checking bench: a default 4-ball engine and a small 1-ball engine
// against a frame-level arithmetic model of ball motion and pixel colour.
module tb_bounce_sprite_engine;
    import bounce_pkg::*;

    localparam int          NB_A  = 4;
    localparam int          R_A   = 16;
    localparam int          H_A   = 640;
    localparam int          V_A   = 480;
    localparam logic [23:0] COL_A = 24'hCF_3F_FC;
    localparam int          NB_B  = 1;
    localparam int          R_B   = 4;
    localparam int          H_B   = 64;
    localparam int          V_B   = 480;
    localparam logic [5:0]  COL_B = 6'h3C;

    localparam int P_NB [2] = '{NB_A, NB_B};
    localparam int P_R  [2] = '{R_A,  R_B};
    localparam int P_H  [2] = '{H_A,  H_B};
    localparam int P_V  [2] = '{V_A,  V_B};

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    bounce_sprite_engine_if bus_a ();
    bounce_sprite_engine_if bus_b ();

    bounce_sprite_engine #(
        .NUM_BALLS(NB_A), .RADIUS(R_A), .H_ACTIVE(H_A), .V_ACTIVE(V_A),
        .SYNC_ACTIVE_LOW(1), .BALL_COLORS(COL_A)
    ) u_dut (.clk(clk), .reset(rst_a), .bus(bus_a));

    bounce_sprite_engine #(
        .NUM_BALLS(NB_B), .RADIUS(R_B), .H_ACTIVE(H_B), .V_ACTIVE(V_B),
        .SYNC_ACTIVE_LOW(1), .BALL_COLORS(COL_B)
    ) u_small (.clk(clk), .reset(rst_b), .bus(bus_b));

    int total = 0;
    int bad   = 0;

    int mx  [2][8];
    int my  [2][8];
    int mvx [2][8];
    int mvy [2][8];
    int mfc [2];

    typedef struct {
        int h;
        int v;
        bit de;
        int exp_rgb;
    } pix_vec_t;

    pix_vec_t vec [13];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset(input int k);
        int r;
        r = P_R[k];
        mfc[k] = 0;
        for (int i = 0; i < P_NB[k]; i++) begin
            mx[k][i]  = r + 1 + i * (2 * r + 8);
            my[k][i]  = P_V[k] / 2;
            mvx[k][i] = (i % 2 == 1) ? -(1 + i % 3) : (1 + i % 3);
            mvy[k][i] = (i % 4 >= 2) ? -(1 + (i + 1) % 3) : (1 + (i + 1) % 3);
        end
    endfunction

    function automatic void step_axis(input int p, input int v, input int lim, input int r,
                                      output int np, output int nv);
        int n;
        n  = p + v;
        np = n;
        nv = v;
        if (v < 0 && n < r) begin
            np = r;
            nv = -v;
        end else if (v > 0 && n > lim - 1 - r) begin
            np = lim - 1 - r;
            nv = -v;
        end
    endfunction

    function automatic void model_frame(input int k);
        int np, nv;
        mfc[k] = (mfc[k] + 1) % 1024;
        for (int i = 0; i < P_NB[k]; i++) begin
            step_axis(mx[k][i], mvx[k][i], P_H[k], P_R[k], np, nv);
            mx[k][i] = np; mvx[k][i] = nv;
            step_axis(my[k][i], mvy[k][i], P_V[k], P_R[k], np, nv);
            my[k][i] = np; mvy[k][i] = nv;
        end
    endfunction

    function automatic int model_pixel(input int h, input int v, input bit de);
        int dx, dy;
        if (!de) return 0;
        for (int i = 0; i < NB_A; i++) begin
            dx = (h > mx[0][i]) ? h - mx[0][i] : mx[0][i] - h;
            dy = (v > my[0][i]) ? v - my[0][i] : my[0][i] - v;
            if (dx * dx + dy * dy < R_A * R_A) return int'(COL_A >> (6 * i)) & 63;
        end
        return ((h >> 7) & 1) * 2 + ((((v + mfc[0]) % 1024) >> 4) & 1);
    endfunction

    task automatic check_balls(input int k, input string name);
        if (k == 0) begin
            for (int i = 0; i < NB_A; i++) begin
                chk($sformatf("%s x%0d", name, i),  int'(u_dut.r_pos_x[i]), mx[0][i]);
                chk($sformatf("%s y%0d", name, i),  int'(u_dut.r_pos_y[i]), my[0][i]);
                chk($sformatf("%s vx%0d", name, i), int'($signed(u_dut.r_vel_x[i])), mvx[0][i]);
                chk($sformatf("%s vy%0d", name, i), int'($signed(u_dut.r_vel_y[i])), mvy[0][i]);
            end
            chk({name, " frame_count"}, int'(bus_a.frame_count), mfc[0]);
        end else begin
            for (int i = 0; i < NB_B; i++) begin
                chk($sformatf("%s x%0d", name, i),  int'(u_small.r_pos_x[i]), mx[1][i]);
                chk($sformatf("%s y%0d", name, i),  int'(u_small.r_pos_y[i]), my[1][i]);
                chk($sformatf("%s vx%0d", name, i), int'($signed(u_small.r_vel_x[i])), mvx[1][i]);
                chk($sformatf("%s vy%0d", name, i), int'($signed(u_small.r_vel_y[i])), mvy[1][i]);
            end
            chk({name, " frame_count"}, int'(bus_b.frame_count), mfc[1]);
        end
    endtask

    // One vsync pulse of 12 clocks; returns how many sampled clocks showed busy.
    task automatic do_tick(input int k, input bit pz, output int bc);
        bc = 0;
        @(negedge clk);
        if (k == 0) begin bus_a.pause = pz; bus_a.vsync_in = 1'b0; end
        else        begin bus_b.pause = pz; bus_b.vsync_in = 1'b0; end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bc += (k == 0) ? int'(bus_a.busy) : int'(bus_b.busy);
        end
        if (k == 0) begin bus_a.vsync_in = 1'b1; bus_a.pause = 1'b0; end
        else        begin bus_b.vsync_in = 1'b1; bus_b.pause = 1'b0; end
        @(negedge clk);
        if (!pz) model_frame(k);
    endtask

    task automatic probe_a(input string name, input int h, input int v, input bit de,
                           input bit hs, input int exp_rgb);
        @(negedge clk);
        bus_a.hpos       = 10'(h);
        bus_a.vpos       = 10'(v);
        bus_a.display_on = de;
        bus_a.hsync_in   = hs;
        @(negedge clk);
        chk({name, " rgb"}, int'(bus_a.rgb), exp_rgb);
        chk({name, " hsync_out"}, int'(bus_a.hsync_out), int'(hs));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, h, v, b, c0;
        bit pz, de, hs;

        vec[0]  = '{17,  240, 1'b1, 6'h3C};
        vec[1]  = '{32,  240, 1'b1, 6'h3C};
        vec[2]  = '{33,  240, 1'b1, 6'h01};
        vec[3]  = '{17,  255, 1'b1, 6'h3C};
        vec[4]  = '{17,  256, 1'b1, 6'h00};
        vec[5]  = '{57,  240, 1'b1, 6'h3F};
        vec[6]  = '{97,  240, 1'b1, 6'h33};
        vec[7]  = '{137, 240, 1'b1, 6'h33};
        vec[8]  = '{147, 252, 1'b1, 6'h33};
        vec[9]  = '{149, 252, 1'b1, 6'h03};
        vec[10] = '{200, 20,  1'b1, 6'h03};
        vec[11] = '{77,  240, 1'b1, 6'h01};
        vec[12] = '{17,  240, 1'b0, 6'h00};

        bus_a.hpos = 10'd0; bus_a.vpos = 10'd0; bus_a.display_on = 1'b1;
        bus_a.hsync_in = 1'b0; bus_a.vsync_in = 1'b1; bus_a.pause = 1'b0;
        bus_b.hpos = 10'd0; bus_b.vpos = 10'd0; bus_b.display_on = 1'b0;
        bus_b.hsync_in = 1'b1; bus_b.vsync_in = 1'b1; bus_b.pause = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset rgb", int'(bus_a.rgb), 0);
        chk("reset busy", int'(bus_a.busy), 0);
        chk("reset frame_count", int'(bus_a.frame_count), 0);
        chk("reset hsync_out", int'(bus_a.hsync_out), 1);
        chk("reset vsync_out", int'(bus_a.vsync_out), 1);
        bus_a.hsync_in = 1'b1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        model_reset(0);
        model_reset(1);
        chk("reset ball0 x", int'(u_dut.r_pos_x[0]), 17);
        chk("reset ball0 y", int'(u_dut.r_pos_y[0]), 240);
        chk("reset ball0 vx", int'($signed(u_dut.r_vel_x[0])), 1);
        chk("reset ball0 vy", int'($signed(u_dut.r_vel_y[0])), 2);
        chk("reset ball1 x", int'(u_dut.r_pos_x[1]), 57);
        chk("reset ball1 vx", int'($signed(u_dut.r_vel_x[1])), -2);
        chk("reset ball1 vy", int'($signed(u_dut.r_vel_y[1])), 3);
        check_balls(0, "reset model");

        for (int i = 0; i < 13; i++) begin
            probe_a($sformatf("vec%0d", i), vec[i].h, vec[i].v, vec[i].de, 1'b1, vec[i].exp_rgb);
        end

        do_tick(0, 1'b0, bc);
        chk("tick1 busy cycles", bc, 4);
        chk("tick1 ball0 x", int'(u_dut.r_pos_x[0]), 18);
        chk("tick1 ball0 y", int'(u_dut.r_pos_y[0]), 242);
        chk("tick1 ball1 x", int'(u_dut.r_pos_x[1]), 55);
        chk("tick1 ball1 y", int'(u_dut.r_pos_y[1]), 243);
        chk("tick1 frame_count", int'(bus_a.frame_count), 1);
        check_balls(0, "tick1 model");
        c0 = int'(COL_A[5:0]);
        probe_a("centre ball0", 18, 242, 1'b1, 1'b0, c0);
        probe_a("edge dx16", 34, 242, 1'b1, 1'b1, 6'h01);
        probe_a("blanked", 18, 242, 1'b0, 1'b0, 0);

        for (int t = 0; t < 3; t++) begin
            do_tick(0, 1'b1, bc);
            chk("paused busy cycles", bc, 0);
        end
        check_balls(0, "after pause");

        // Second vsync edge lands two clocks into the sweep and must be dropped.
        @(negedge clk);
        bus_a.vsync_in = 1'b0;
        bc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bc += int'(bus_a.busy);
            bus_a.vsync_in = (c == 1 || c == 2) ? 1'b0 : 1'b1;
        end
        model_frame(0);
        chk("tick-while-busy busy cycles", bc, 4);
        check_balls(0, "tick-while-busy");

        for (int it = 0; it < 250; it++) begin
            pz = ($urandom_range(0, 3) == 0);
            do_tick(0, pz, bc);
            chk("rand busy cycles", bc, pz ? 0 : 4);
            check_balls(0, "rand");
            for (int p = 0; p < 6; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    b = $urandom_range(0, NB_A - 1);
                    h = mx[0][b] + int'($urandom_range(0, 40)) - 20;
                    v = my[0][b] + int'($urandom_range(0, 40)) - 20;
                    if (h < 0) h = 0;
                    if (v < 0) v = 0;
                end else begin
                    h = $urandom_range(0, H_A - 1);
                    v = $urandom_range(0, V_A - 1);
                end
                de = ($urandom_range(0, 7) != 0);
                hs = 1'($urandom_range(0, 1));
                probe_a("rand pixel", h, v, de, hs, model_pixel(h, v, de));
            end
        end

        // Reset asserted while the sweep is on ball index 2.
        @(negedge clk);
        bus_a.vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-update idx", int'(u_dut.r_idx), 2);
        chk("mid-update busy", int'(bus_a.busy), 1);
        rst_a = 1'b1;
        #1;
        model_reset(0);
        chk("reset abort busy", int'(bus_a.busy), 0);
        check_balls(0, "reset abort");
        @(negedge clk);
        bus_a.vsync_in = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        do_tick(0, 1'b0, bc);
        chk("post-reset busy cycles", bc, 4);
        check_balls(0, "post-reset tick");

        for (int f = 1; f <= 111; f++) begin
            do_tick(1, 1'b0, bc);
            chk("small busy cycles", bc, 1);
            check_balls(1, $sformatf("small f%0d", f));
            if (f == 54) chk("f54 x", int'(u_small.r_pos_x[0]), 59);
            if (f == 55) begin
                chk("f55 x", int'(u_small.r_pos_x[0]), 59);
                chk("f55 vx", int'($signed(u_small.r_vel_x[0])), -1);
            end
            if (f == 56) chk("f56 x", int'(u_small.r_pos_x[0]), 58);
            if (f == 110) begin
                chk("f110 x", int'(u_small.r_pos_x[0]), 4);
                chk("f110 vx", int'($signed(u_small.r_vel_x[0])), -1);
            end
            if (f == 111) begin
                chk("f111 x", int'(u_small.r_pos_x[0]), 4);
                chk("f111 vx", int'($signed(u_small.r_vel_x[0])), 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
